// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Defining LU_FLAGS_EN adds the out_zero/out_neg result flags.
interface logic_unit_pipe_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [4:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_c;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
`ifdef LU_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag, out_illegal
`ifdef LU_FLAGS_EN
        , output out_zero, out_neg
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag, out_illegal
`ifdef LU_FLAGS_EN
        , input out_zero, out_neg
`endif
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Elastic pipelined VLIW logic unit: bitwise ops + NEG, slot tag, illegal flag, flush.
// Optional result flags (out_zero/out_neg) are enabled by defining LU_FLAGS_EN.
module logic_unit_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    logic_unit_pipe_if.slave  bus
);
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_XOR  = 5'b01100;
    localparam logic [4:0] OP_NAND = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_XNOR = 5'b01111;
    localparam logic [4:0] OP_NOT  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;

    logic [N-1:0] comp_c;
    logic         comp_ill;

    always_comb begin
        comp_c   = '0;
        comp_ill = 1'b0;
        case (bus.in_op)
            OP_AND:  comp_c = bus.in_a & bus.in_b;
            OP_OR:   comp_c = bus.in_a | bus.in_b;
            OP_XOR:  comp_c = bus.in_a ^ bus.in_b;
            OP_NAND: comp_c = ~(bus.in_a & bus.in_b);
            OP_NOR:  comp_c = ~(bus.in_a | bus.in_b);
            OP_XNOR: comp_c = ~(bus.in_a ^ bus.in_b);
            OP_NOT:  comp_c = ~bus.in_a;
            OP_NEG:  comp_c = '0 - bus.in_a;
            default: comp_ill = 1'b1;
        endcase
    end

    logic [STAGES-1:0] valid_q, valid_d, load, src_v;
    logic [STAGES-1:0] ill_q, ill_d, src_ill;
    logic [N-1:0]      c_q     [STAGES];
    logic [N-1:0]      c_d     [STAGES];
    logic [N-1:0]      src_c   [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_d   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
`ifdef LU_FLAGS_EN
    logic [STAGES-1:0] zero_q, zero_d, src_zero;
    logic [STAGES-1:0] neg_q, neg_d, src_neg;
`endif

    // A stage may load when some stage at or after it is empty, or the output drains:
    // the whole valid run behind that hole shifts forward by one.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            assign load[gi] = bus.out_ready | ~(&valid_q[STAGES-1:gi]);
            if (gi == 0) begin : g_head
                assign src_v[gi]   = bus.in_valid;
                assign src_c[gi]   = comp_c;
                assign src_tag[gi] = bus.in_tag;
                assign src_ill[gi] = comp_ill;
`ifdef LU_FLAGS_EN
                assign src_zero[gi] = !comp_ill && (comp_c == '0);
                assign src_neg[gi]  = !comp_ill && comp_c[N-1];
`endif
            end else begin : g_body
                assign src_v[gi]   = valid_q[gi-1];
                assign src_c[gi]   = c_q[gi-1];
                assign src_tag[gi] = tag_q[gi-1];
                assign src_ill[gi] = ill_q[gi-1];
`ifdef LU_FLAGS_EN
                assign src_zero[gi] = zero_q[gi-1];
                assign src_neg[gi]  = neg_q[gi-1];
`endif
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        ill_d   = ill_q;
`ifdef LU_FLAGS_EN
        zero_d  = zero_q;
        neg_d   = neg_q;
`endif
        for (int k = 0; k < STAGES; k++) begin
            c_d[k]   = c_q[k];
            tag_d[k] = tag_q[k];
            if (load[k]) begin
                valid_d[k] = src_v[k];
                c_d[k]     = src_c[k];
                tag_d[k]   = src_tag[k];
                ill_d[k]   = src_ill[k];
`ifdef LU_FLAGS_EN
                zero_d[k]  = src_zero[k];
                neg_d[k]   = src_neg[k];
`endif
            end
            // Squash drops occupancy only; stale data is harmless behind a clear valid.
            if (flush) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            ill_q   <= '0;
`ifdef LU_FLAGS_EN
            zero_q  <= '0;
            neg_q   <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                c_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ill_q   <= ill_d;
`ifdef LU_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                c_q[k]   <= c_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign bus.in_ready    = !flush && load[0];
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.out_c       = c_q[STAGES-1];
    assign bus.out_tag     = tag_q[STAGES-1];
    assign bus.out_illegal = ill_q[STAGES-1];
`ifdef LU_FLAGS_EN
    assign bus.out_zero    = zero_q[STAGES-1];
    assign bus.out_neg     = neg_q[STAGES-1];
`endif
endmodule
